// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window controller: FSM states, default pixel width
// and the packed 3x3 window layout seen by the Gradient datapath.
package sobel_pkg;

  localparam int NBIT_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [NBIT_DEFAULT-1:0] p0;
    logic [NBIT_DEFAULT-1:0] p1;
    logic [NBIT_DEFAULT-1:0] p2;
    logic [NBIT_DEFAULT-1:0] p3;
    logic [NBIT_DEFAULT-1:0] p4;
    logic [NBIT_DEFAULT-1:0] p5;
    logic [NBIT_DEFAULT-1:0] p6;
    logic [NBIT_DEFAULT-1:0] p7;
    logic [NBIT_DEFAULT-1:0] p8;
  } window_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// Two row-history buffers indexed by column; each accept reads both rows at the
// column and pushes the new pixel down one row in a single read-modify-write.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int NBIT  = NBIT_DEFAULT,
  parameter int IMG_W = 640
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(IMG_W)-1:0] addr,
  input  logic [NBIT-1:0]          din,
  output logic [NBIT-1:0]          rd0,
  output logic [NBIT-1:0]          rd1
);

  logic [NBIT-1:0] lb0_r [IMG_W];
  logic [NBIT-1:0] lb1_r [IMG_W];

  assign rd0 = lb0_r[addr];
  assign rd1 = lb1_r[addr];

  // Row shift on accept: row y-1 moves to the y-2 slot, new pixel becomes row y-1.
  always_ff @(posedge clk) begin
    if (we) begin
      lb1_r[addr] <= lb0_r[addr];
      lb0_r[addr] <= din;
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Frame controller that turns a raster pixel stream into 3x3 interior windows
// (plus latched threshold) for the combinational Sobel Gradient stage.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int NBIT  = NBIT_DEFAULT,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NBIT-1:0]          thr_in,
  input  logic [NBIT-1:0]          pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [NBIT-1:0]          P0,
  output logic [NBIT-1:0]          P1,
  output logic [NBIT-1:0]          P2,
  output logic [NBIT-1:0]          P3,
  output logic [NBIT-1:0]          P4,
  output logic [NBIT-1:0]          P5,
  output logic [NBIT-1:0]          P6,
  output logic [NBIT-1:0]          P7,
  output logic [NBIT-1:0]          P8,
  output logic [NBIT-1:0]          T,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     busy,
  output logic                     done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  state_t          state_r;
  logic [XW-1:0]   x_r;
  logic [YW-1:0]   y_r;
  logic            last_taken_r;
  logic [NBIT-1:0] win_r [9];
  logic [NBIT-1:0] lb0_rd_s;
  logic [NBIT-1:0] lb1_rd_s;
  logic            accept_s;
  logic            qualify_s;
  logic            last_pix_s;
  logic            handoff_s;

  // Ready is combinational on win_ready so a handshake and an accept can share a cycle.
  assign pix_ready  = (state_r == RUN) && !last_taken_r && (!win_valid || win_ready);
  assign accept_s   = pix_valid && pix_ready;
  assign qualify_s  = (y_r >= Y_TWO) && (x_r >= X_TWO);
  assign last_pix_s = (x_r == X_LAST) && (y_r == Y_LAST);
  assign handoff_s  = win_valid && win_ready;

  assign P0 = win_r[0];
  assign P1 = win_r[1];
  assign P2 = win_r[2];
  assign P3 = win_r[3];
  assign P4 = win_r[4];
  assign P5 = win_r[5];
  assign P6 = win_r[6];
  assign P7 = win_r[7];
  assign P8 = win_r[8];

  sobel_line_buffer #(
    .NBIT  (NBIT),
    .IMG_W (IMG_W)
  ) u_lb (
    .clk  (clk),
    .we   (accept_s),
    .addr (x_r),
    .din  (pix_in),
    .rd0  (lb0_rd_s),
    .rd1  (lb1_rd_s)
  );

  // Frame FSM, raster counters, window shift registers and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      x_r          <= '0;
      y_r          <= '0;
      last_taken_r <= 1'b0;
      win_valid    <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
      T            <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_r[i] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r      <= RUN;
            busy         <= 1'b1;
            x_r          <= '0;
            y_r          <= '0;
            last_taken_r <= 1'b0;
            T            <= thr_in;
          end
        end
        RUN: begin
          if (accept_s) begin
            // Columns slide left; the new right column is {row y-2, row y-1, row y} at x.
            win_r[0]  <= win_r[1];
            win_r[1]  <= win_r[2];
            win_r[2]  <= lb1_rd_s;
            win_r[3]  <= win_r[4];
            win_r[4]  <= win_r[5];
            win_r[5]  <= lb0_rd_s;
            win_r[6]  <= win_r[7];
            win_r[7]  <= win_r[8];
            win_r[8]  <= pix_in;
            win_valid <= qualify_s;
            if (qualify_s) begin
              win_row <= y_r - Y_ONE;
              win_col <= x_r - X_ONE;
            end
            if (x_r == X_LAST) begin
              x_r <= '0;
              if (!last_pix_s) begin
                y_r <= y_r + Y_ONE;
              end
            end else begin
              x_r <= x_r + X_ONE;
            end
            if (last_pix_s) begin
              last_taken_r <= 1'b1;
              if (!qualify_s) begin
                state_r <= DONE;
                done    <= 1'b1;
              end
            end
          end else if (handoff_s) begin
            win_valid <= 1'b0;
            if (last_taken_r) begin
              state_r <= DONE;
              done    <= 1'b1;
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          win_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Randomised bench for sobel_window_ctrl on a 5x4 frame, checked against a
// window list computed directly from the stored image.
module tb_sobel_window_ctrl;

  localparam int W = 5;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst, start, pix_valid, pix_ready, win_valid, win_ready, busy, done;
  logic [7:0] thr_in, pix_in, T;
  logic [7:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
  logic [1:0] win_row;
  logic [2:0] win_col;

  always #5 clk = ~clk;

  sobel_window_ctrl #(.NBIT(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .thr_in(thr_in), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .P0(P0), .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5), .P6(P6), .P7(P7), .P8(P8),
    .T(T), .win_valid(win_valid), .win_ready(win_ready),
    .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [71:0] p;
    logic [1:0]  row;
    logic [2:0]  col;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp_e;
  logic [7:0]  img [N];
  logic [7:0]  exp_thr = 8'h00;
  int          n_checks = 0;
  int          n_fail = 0;
  int          win_seen = 0;
  int          done_seen = 0;
  logic [71:0] first_win, last_win, prev_win;
  logic [4:0]  last_rc, prev_rc;
  logic        prev_stall = 1'b0;
  wire  [71:0] dut_win = {P0, P1, P2, P3, P4, P5, P6, P7, P8};

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Expected windows: every interior centre in raster order, neighbours straight from the image.
  function automatic void build_exp();
    exp_t e;
    exp_q.delete();
    for (int r = 1; r <= H - 2; r++) begin
      for (int c = 1; c <= W - 2; c++) begin
        e.p   = {img[(r-1)*W+c-1], img[(r-1)*W+c], img[(r-1)*W+c+1],
                 img[r*W+c-1],     img[r*W+c],     img[r*W+c+1],
                 img[(r+1)*W+c-1], img[(r+1)*W+c], img[(r+1)*W+c+1]};
        e.row = 2'(r);
        e.col = 3'(c);
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_pix_ready"}, 72'(pix_ready), 72'(0));
    chk({tag, "_win_valid"}, 72'(win_valid), 72'(0));
    chk({tag, "_busy"}, 72'(busy), 72'(0));
    chk({tag, "_done"}, 72'(done), 72'(0));
    chk({tag, "_T"}, 72'(T), 72'(0));
    chk({tag, "_window"}, dut_win, 72'(0));
    chk({tag, "_rowcol"}, 72'({win_row, win_col}), 72'(0));
  endtask

  // Compare process: every cycle, away from the clock edge.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_window", dut_win, prev_win);
        chk("stall_rowcol", 72'({win_row, win_col}), 72'(prev_rc));
        chk("stall_valid", 72'(win_valid), 72'(1));
      end
      if (win_valid && !win_ready) chk("bp_pix_ready", 72'(pix_ready), 72'(0));
      if (busy) chk("thr_hold", 72'(T), 72'(exp_thr));
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_window: actual row %0d col %0d required none", win_row, win_col);
        end else begin
          exp_e = exp_q.pop_front();
          chk("win_pixels", dut_win, exp_e.p);
          chk("win_rowcol", 72'({win_row, win_col}), 72'({exp_e.row, exp_e.col}));
        end
        if (win_seen == 0) first_win = dut_win;
        last_win = dut_win;
        last_rc  = {win_row, win_col};
        win_seen++;
      end
      if (done) done_seen++;
      prev_stall = win_valid && !win_ready;
      prev_win   = dut_win;
      prev_rc    = {win_row, win_col};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // mode 0: win_ready=1; mode 1: hold ready low 5 cycles on 3rd window; mode 2: random ready.
  task automatic run_frame(input int gap, input int mode, input int abort_at,
                           input int restart_at, input logic [7:0] thr, input int exp_cycles);
    int idx, cyc, stalls;
    bit fin;
    build_exp();
    win_seen  = 0;
    done_seen = 0;
    exp_thr   = thr;
    idx = 0; stalls = 0; fin = 1'b0;
    @(negedge clk);
    start = 1'b1; thr_in = thr; pix_valid = 1'b0; win_ready = 1'b1;
    cyc = 0;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start  = (cyc == restart_at);
      thr_in = 8'($urandom);
      if (abort_at > 0 && idx == abort_at) begin
        rst = 1'b1; pix_valid = 1'b0; win_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0; win_ready = 1'b1;
        #1;
        check_reset("abort");
        exp_q.delete();
        return;
      end
      pix_valid = (idx < N) && (int'($urandom_range(99)) >= gap);
      pix_in    = (idx < N) ? img[idx] : 8'h00;
      case (mode)
        1: begin
          if (win_valid && win_seen == 2 && stalls < 5) begin
            win_ready = 1'b0;
            stalls++;
          end else begin
            win_ready = 1'b1;
          end
        end
        2:       win_ready = 1'($urandom_range(1));
        default: win_ready = 1'b1;
      endcase
      #1;
      if (pix_valid && pix_ready) idx++;
      if (done) fin = 1'b1;
    end
    chk("done_reached", 72'(fin), 72'(1));
    chk("pixels_taken", 72'(idx), 72'(N));
    if (exp_cycles > 0) chk("frame_cycles", 72'(cyc), 72'(exp_cycles));
    if (mode == 1) chk("stall_cycles", 72'(stalls), 72'(5));
    @(negedge clk);
    pix_valid = 1'b0; win_ready = 1'b1;
    #1;
    chk("done_one_cycle", 72'(done), 72'(0));
    chk("idle_busy", 72'(busy), 72'(0));
    repeat (3) @(negedge clk);
    chk("windows_total", 72'(win_seen), 72'((W-2)*(H-2)));
    chk("done_count", 72'(done_seen), 72'(1));
    chk("model_drained", 72'(exp_q.size()), 72'(0));
  endtask

  task automatic ramp_image();
    for (int i = 0; i < N; i++) img[i] = 8'(16 * (i / W) + (i % W));
  endtask

  task automatic random_image();
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; thr_in = 8'h00; pix_in = 8'h00;
    pix_valid = 1'b0; win_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset("por");
    rst = 1'b0;

    // Pin the model against hand-computed values for the 16*y+x frame.
    ramp_image();
    build_exp();
    chk("model_count", 72'(exp_q.size()), 72'(6));
    chk("model_first", exp_q[0].p, 72'h00_01_02_10_11_12_20_21_22);
    chk("model_first_rc", 72'({exp_q[0].row, exp_q[0].col}), 72'({2'd1, 3'd1}));
    chk("model_last_p8", 72'(exp_q[5].p[7:0]), 72'(8'h34));
    chk("model_last_rc", 72'({exp_q[5].row, exp_q[5].col}), 72'({2'd2, 3'd3}));

    run_frame(0, 0, 0, -1, 8'h2A, N + 2);
    chk("dut_first_win", first_win, 72'h00_01_02_10_11_12_20_21_22);
    chk("dut_last_p8", 72'(last_win[7:0]), 72'(8'h34));
    chk("dut_last_rc", 72'(last_rc), 72'({2'd2, 3'd3}));

    run_frame(30, 0, 0, -1, 8'h3C, 0);
    run_frame(0, 1, 0, -1, 8'h11, 0);

    random_image();
    img[0] = 8'd0;  img[1] = 8'd138;  img[2] = 8'd138;
    img[5] = 8'd0;  img[6] = 8'd138;  img[7] = 8'd133;
    img[10] = 8'd0; img[11] = 8'd138; img[12] = 8'd138;
    run_frame(0, 0, 0, -1, 8'd10, N + 2);
    chk("sobel_window", first_win, {8'd0, 8'd138, 8'd138, 8'd0, 8'd138, 8'd133, 8'd0, 8'd138, 8'd138});

    for (int k = 0; k < 3; k++) begin
      random_image();
      run_frame(30, 2, 0, -1, 8'($urandom), 0);
    end

    ramp_image();
    run_frame(0, 0, 9, -1, 8'h77, 0);
    run_frame(0, 0, 0, -1, 8'h21, N + 2);

    random_image();
    run_frame(0, 0, 0, 5, 8'h55, N + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Frame-level controller that sequences the combinational Sobel `Gradient` datapath. It accepts a raster-order pixel stream over a valid/ready handshake and keeps two line buffers plus a 3x3 shift window. For every interior pixel it presents the nine neighbours `P0..P8` and the frame threshold `T` to `Gradient`, with `win_valid`/`win_ready` flow control. It sits between the pixel source (memory reader or camera interface) and the `Gradient` instance.

## Interface
- `NBIT`, 8, pixel and threshold width
- `IMG_W`, 640, pixels per row (≥3)
- `IMG_H`, 480, rows per frame (≥3)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin frame; sampled only in IDLE
- `thr_in`  in  NBIT  threshold, latched on accepted `start`
- `pix_in`  in  NBIT  raster pixel
- `pix_valid`  in  1  `pix_in` valid
- `pix_ready`  out  1  controller accepts pixel this cycle
- `P0..P8`  out  NBIT each  window to `Gradient`
- `T`  out  NBIT  latched threshold to `Gradient`
- `win_valid`  out  1  window registers hold a valid interior window
- `win_ready`  in  1  consumer takes window
- `win_row`  out  clog2(IMG_H)  centre row of current window
- `win_col`  out  clog2(IMG_W)  centre column of current window
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse at frame end

## Operation
- **States:**
  - IDLE: `start` → RUN; clears the x/y counters and latches `thr_in` into `T`.
  - RUN: accepts pixels. On the last window handshake (or the last pixel accept if `win_valid` is already clear) → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- **Pixel acceptance:** a pixel is accepted when `pix_valid && pix_ready`. `pix_ready` = RUN && !last_pixel_taken && (!`win_valid` || `win_ready`).
- **Counters:** x runs 0..IMG_W-1 and wraps to 0 with y+1. Once pixel (IMG_H-1, IMG_W-1) is accepted, no further pixels are accepted.
- **Line buffers on accept at column x:**
  - Read `lb0[x]` (row y-1) and `lb1[x]` (row y-2).
  - Write `lb1[x]` ← `lb0[x]`, `lb0[x]` ← `pix_in`.
- **Window shift:** each column of the 3x3 window shifts left. The new right column is {`lb1[x]`, `lb0[x]`, `pix_in`}.
- **Window mapping:** `P0` = (y-2,x-2), `P1` = (y-2,x-1), `P2` = (y-2,x), `P3` = (y-1,x-2), `P4` = (y-1,x-1), `P5` = (y-1,x), `P6` = (y,x-2), `P7` = (y,x-1), `P8` = (y,x).
- **Window emission:** a window is emitted only when the accepted pixel has y≥2 and x≥2. Then `win_row` = y-1 and `win_col` = x-1. Border centres are never emitted, so a frame yields exactly (IMG_W-2)(IMG_H-2) windows.
- **Row wrap:** windows never straddle a row boundary, because x≥2 is required and the window shift register fills fresh in every row.
- **Threshold stability:** `T` is constant from `start` to `done`. `thr_in` changes mid-frame are ignored.
- **Start handling:** `start` outside IDLE is ignored.
- **Reset mid-frame:** controller returns to IDLE. Counters, `win_valid`, `busy` and `done` are cleared and `T` is set to 0. Line-buffer RAM contents are not cleared; they are rewritten before use.

## Timing
- **Reset values:** `pix_ready`=0, `win_valid`=0, `busy`=0, `done`=0, `T`=0, `P0..P8`=0, `win_row`=0, `win_col`=0.
- **Start latency:** `start` is accepted at edge N. `busy` and `pix_ready` can be 1 from cycle N+1.
- **Window latency:** a qualifying pixel accepted at edge N gives `win_valid`=1 with its window at cycle N+1 (one-cycle registered latency).
- **Backpressure:** while `win_valid` && !`win_ready`, `P0..P8`, `win_row` and `win_col` hold and `pix_ready`=0.
- **Back-to-back throughput:** with `win_ready` held 1, a pixel accept and a window handshake in the same cycle sustain 1 pixel/cycle.
- **Non-qualifying accept:** an accept that does not qualify while the current window is handed off clears `win_valid` next cycle.
- **Frame end:** `done` is asserted the cycle after the final window handshake. With 1-cycle `win_ready`, a full frame takes IMG_W·IMG_H + 2 cycles from `start` to `done`.
- **Datapath:** `Gradient` stays purely combinational on `P0..P8`/`T`. Its outputs are qualified by `win_valid`.

## Structure
- **Package `sobel_pkg`:**
  - `NBIT` default.
  - State enum `{IDLE, RUN, DONE}`.
  - Packed 3x3 window typedef of nine `NBIT` fields ordered `P0..P8`.
- **Sub-module `sobel_line_buffer`:** two IMG_W×NBIT arrays with a single read-modify-write per accept, inferable as dual-port RAM.
- **Controller:** counters, FSM, window shift registers and output registers.

## Test plan
- **Minimal frame:** IMG_W=5, IMG_H=4, pixel = 16·y+x, `win_ready`=1 → 6 windows. The first has `P0..P8` = 0x00,01,02,10,11,12,20,21,22 with `win_row`=1, `win_col`=1. The last has centre (2,3) and `P8`=0x34. `done` fires exactly once.
- **Sobel values:** a frame whose window at (1,1) is 0,138,138,0,138,133,0,138,138 with `thr_in`=10 → `P0..P8` match exactly and `T`=10 for the whole frame, even with `thr_in` changed mid-frame.
- **Backpressure:** `win_ready` held 0 for 5 cycles on the 3rd window → `pix_ready`=0, window and `win_row`/`win_col` stable. No pixel is lost or duplicated, and the total stays 6.
- **Source gaps:** random `pix_valid` gaps (30%) → window sequence identical to the gap-free run.
- **Reset mid-frame:** `rst` after 9 pixels → next cycle all outputs at reset values. A new `start` gives a correct full 6-window frame.
- **Ignored start:** `start` pulsed during RUN → no effect, `busy` stays 1 and the frame completes normally.
